// File: rtl/am_envelope_decim.sv
// AM envelope demodulator: rectifier, 2nd-order CIC decimator,
// leaky DC remover and block peak detector for gain control.
module am_envelope_decim #(
   parameter int DEC_LOG2  = 6,
   parameter int DC_SHIFT  = 4,
   parameter int PEAK_LOG2 = 8
) (
   input  logic       clk,
   input  logic       RSTb,
   input  logic [7:0] if_filt_in,
   output logic [7:0] audio_out,
   output logic       audio_valid,
   output logic [7:0] env_out,
   output logic [7:0] level_out,
   output logic       level_valid
);

   localparam int W  = 7 + 2 * DEC_LOG2;
   localparam int DW = 8 + DC_SHIFT;

   logic [6:0]           r;
   logic [W-1:0]         i1, i2, i2_d;
   logic [W-1:0]         c1, c1_d, c2;
   logic [DEC_LOG2-1:0]  cnt;
   logic                 stb_d1, stb_d2;
   logic [1:0]           warm;
   logic [DW-1:0]        dc;
   logic [7:0]           pk;
   logic [PEAK_LOG2-1:0] bcnt;

   logic                 dec_stb;
   logic [7:0]           env;
   logic [7:0]           pk_nxt;
   logic signed [8:0]    a;
   logic signed [DW:0]   dc_diff;
   logic signed [DW:0]   dc_step;
   logic [DW-1:0]        dc_nxt;

   assign dec_stb = (cnt == '1);
   assign env     = 8'(c2 >> (W - 8));
   assign pk_nxt  = (env > pk) ? env : pk;

   // dc carries the estimate scaled by 2^DC_SHIFT; its integer part is subtracted
   assign a       = $signed({1'b0, env}) - $signed({1'b0, dc[DW-1:DC_SHIFT]});
   assign dc_diff = $signed({1'b0, env, {DC_SHIFT{1'b0}}}) - $signed({1'b0, dc});
   assign dc_step = dc_diff >>> DC_SHIFT;
   assign dc_nxt  = dc + DW'(dc_step);

   // rectifier, integrators and decimation counter
   always_ff @(posedge clk) begin
      if (!RSTb) begin
         r   <= '0;
         i1  <= '0;
         i2  <= '0;
         cnt <= '0;
      end else begin
         if (if_filt_in == 8'h80)
            r <= 7'd127;
         else if (if_filt_in[7])
            r <= 7'(-if_filt_in);
         else
            r <= if_filt_in[6:0];
         i1  <= i1 + W'(r);
         i2  <= i2 + i1;
         cnt <= cnt + 1'b1;
      end
   end

   // comb sections, one stage per cycle after the decimation strobe
   always_ff @(posedge clk) begin
      if (!RSTb) begin
         c1     <= '0;
         c1_d   <= '0;
         c2     <= '0;
         i2_d   <= '0;
         stb_d1 <= 1'b0;
         stb_d2 <= 1'b0;
      end else begin
         stb_d1 <= dec_stb;
         stb_d2 <= stb_d1;
         if (dec_stb) begin
            c1   <= i2 - i2_d;
            i2_d <= i2;
         end
         if (stb_d1) begin
            c2   <= c1 - c1_d;
            c1_d <= c1;
         end
      end
   end

   // warm-up gating, DC removal, peak tracking and output strobes
   always_ff @(posedge clk) begin
      if (!RSTb) begin
         warm        <= '0;
         dc          <= '0;
         pk          <= '0;
         bcnt        <= '0;
         audio_out   <= '0;
         audio_valid <= 1'b0;
         env_out     <= '0;
         level_out   <= '0;
         level_valid <= 1'b0;
      end else begin
         audio_valid <= 1'b0;
         level_valid <= 1'b0;
         if (stb_d2) begin
            if (warm != 2'd2) begin
               warm <= warm + 1'b1;
            end else begin
               if (a > 9'sd127)
                  audio_out <= 8'h7F;
               else if (a < -9'sd128)
                  audio_out <= 8'h80;
               else
                  audio_out <= a[7:0];
               env_out     <= env;
               audio_valid <= 1'b1;
               dc          <= dc_nxt;
               bcnt        <= bcnt + 1'b1;
               if (bcnt == '1) begin
                  level_out   <= pk_nxt;
                  level_valid <= 1'b1;
                  pk          <= '0;
               end else begin
                  pk <= pk_nxt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_am_envelope_decim.sv
// Self-checking bench for am_envelope_decim against a
// direct-convolution reference model of the demodulator.
module tb_am_envelope_decim;

   logic       clk;
   logic       RSTb;
   logic [7:0] if_filt_in;
   logic [7:0] audio_out;
   logic       audio_valid;
   logic [7:0] env_out;
   logic [7:0] level_out;
   logic       level_valid;

   am_envelope_decim dut (
      .clk         (clk),
      .RSTb        (RSTb),
      .if_filt_in  (if_filt_in),
      .audio_out   (audio_out),
      .audio_valid (audio_valid),
      .env_out     (env_out),
      .level_out   (level_out),
      .level_valid (level_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   int hist [256];
   int edge_no = 0;
   int rst_edge = 0;
   int dcs = 0;
   int pk = 0;
   int nsamp = 0;
   logic       e_av = 1'b0;
   logic       e_lv = 1'b0;
   logic [7:0] e_audio = '0;
   logic [7:0] e_env = '0;
   logic [7:0] e_level = '0;

   function automatic int rect(input logic [7:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0) v = -v;
      if (v > 127) v = 127;
      return v;
   endfunction

   // CIC2 with R=64 is a triangular FIR of length 127 (sum of taps 4096)
   function automatic int tri_w(input int d);
      return (d <= 63) ? d + 1 : 127 - d;
   endfunction

   task automatic tick(input logic [7:0] x, input bit rst);
      int y, env, a, since;
      if_filt_in = x;
      RSTb = !rst;
      @(posedge clk);
      edge_no++;
      e_lv = 1'b0;
      if (rst) begin
         for (int i = 0; i < 256; i++) hist[i] = 0;
         rst_edge = edge_no;
         dcs = 0; pk = 0; nsamp = 0;
         e_av = 1'b0;
         e_audio = '0; e_env = '0; e_level = '0;
      end else begin
         hist[edge_no % 256] = rect(x);
         since = edge_no - rst_edge;
         e_av = (since >= 194) && (((since - 194) % 64) == 0);
         if (e_av) begin
            y = 0;
            for (int d = 0; d < 127; d++)
               y += tri_w(d) * hist[(edge_no - 5 - d) % 256];
            env = y / 2048;
            a = env - (dcs >>> 4);
            if (a > 127) a = 127;
            if (a < -128) a = -128;
            dcs = dcs + ((env * 16 - dcs) >>> 4);
            e_audio = 8'(a);
            e_env = 8'(env);
            if (env > pk) pk = env;
            nsamp++;
            if (nsamp % 256 == 0) begin
               e_lv = 1'b1;
               e_level = 8'(pk);
               pk = 0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(8'h55, 1'b1);
      checks++;
      if ({audio_valid, level_valid, audio_out, env_out, level_out} !== 26'd0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=0",
                  {audio_valid, level_valid, audio_out, env_out, level_out});
      end
   endtask

   task automatic test_zero();
      int nv = 0, first = -1;
      tick(8'h00, 1'b1);
      for (int i = 1; i <= 384; i++) begin
         tick(8'h00, 1'b0);
         if (audio_valid) begin
            nv++;
            if (first < 0) first = i;
         end
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL zero_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
      end
      checks++;
      if (first != 194 || nv != 3) begin
         failures++;
         $display("FAIL zero_timing first=%0d n=%0d exp first=194 n=3", first, nv);
      end
   endtask

   task automatic test_const_pos();
      int ns = 0;
      tick(8'd100, 1'b1);
      for (int i = 0; i < 64 * 212; i++) begin
         tick(8'd100, 1'b0);
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL const_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
         if (audio_valid) begin
            ns++;
            checks++;
            if (env_out !== 8'd200) begin
               failures++;
               if (failures < 20)
                  $display("FAIL const_env s=%0d got=%0d exp=200", ns, env_out);
            end
            if (ns <= 2) begin
               checks++;
               if (audio_out !== 8'd127) begin
                  failures++;
                  $display("FAIL const_sat s=%0d got=%0d exp=127", ns, audio_out);
               end
            end
            if (ns >= 200) begin
               checks++;
               if ($signed(audio_out) > 2 || $signed(audio_out) < -2) begin
                  failures++;
                  if (failures < 20)
                     $display("FAIL const_decay s=%0d got=%0d exp=|x|<=2",
                              ns, $signed(audio_out));
               end
            end
         end
      end
   endtask

   task automatic test_neg_sat();
      tick(8'h80, 1'b1);
      for (int i = 0; i < 64 * 40; i++) begin
         tick(8'h80, 1'b0);
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL neg_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
         if (audio_valid) begin
            checks++;
            if (env_out !== 8'd254) begin
               failures++;
               if (failures < 20)
                  $display("FAIL neg_env cyc=%0d got=%0d exp=254", i, env_out);
            end
         end
      end
   endtask

   task automatic test_am_tone();
      int amp, nl = 0;
      logic [7:0] x;
      tick(8'h00, 1'b1);
      for (int n = 0; n < 64 * 516; n++) begin
         amp = $rtoi(64.0 * (1.0 + 0.5 * $sin(2.0 * 3.14159265358979 * n / 2048.0)) + 0.5);
         x = (n % 2 == 1) ? 8'(-amp) : 8'(amp);
         tick(x, 1'b0);
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL am_model cyc=%0d got=%h exp=%h", n,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
         if (level_valid) begin
            nl++;
            checks++;
            if (level_out < 8'd190 || level_out > 8'd194) begin
               failures++;
               $display("FAIL am_level got=%0d exp=192+-2", level_out);
            end
         end
      end
      checks++;
      if (nl != 2) begin
         failures++;
         $display("FAIL am_level_count got=%0d exp=2", nl);
      end
   endtask

   task automatic test_random();
      tick(8'h00, 1'b1);
      for (int i = 0; i < 64 * 24; i++) begin
         tick(8'($urandom), 1'b0);
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL rand_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
      end
   endtask

   task automatic test_alternating();
      int ns = 0;
      tick(8'h7F, 1'b1);
      for (int i = 0; i < 64 * 10; i++) begin
         tick((i % 2 == 0) ? 8'h80 : 8'h7F, 1'b0);
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL alt_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
         if (audio_valid) begin
            ns++;
            checks++;
            if (env_out !== 8'd254 || (ns == 1 && audio_out !== 8'd127)) begin
               failures++;
               $display("FAIL alt_sat s=%0d env=%0d audio=%0d exp env=254 audio=127",
                        ns, env_out, audio_out);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int first = -1;
      tick(8'd100, 1'b1);
      for (int i = 0; i < 64 * 3 + 40; i++) tick(8'(100 + (i % 7)), 1'b0);
      tick(8'd100, 1'b1);
      checks++;
      if ({audio_valid, level_valid, audio_out, env_out, level_out} !== 26'd0) begin
         failures++;
         $display("FAIL midreset_clear got=%h exp=0",
                  {audio_valid, level_valid, audio_out, env_out, level_out});
      end
      for (int i = 1; i <= 300; i++) begin
         tick(8'(60 + (i % 5)), 1'b0);
         if (audio_valid && first < 0) first = i;
         checks++;
         if ({audio_valid, level_valid, audio_out, env_out, level_out} !==
             {e_av, e_lv, e_audio, e_env, e_level}) begin
            failures++;
            if (failures < 20)
               $display("FAIL midreset_model cyc=%0d got=%h exp=%h", i,
                  {audio_valid, level_valid, audio_out, env_out, level_out},
                  {e_av, e_lv, e_audio, e_env, e_level});
         end
      end
      checks++;
      if (first != 194) begin
         failures++;
         $display("FAIL midreset_latency got=%0d exp=194", first);
      end
   endtask

   initial begin
      RSTb = 1'b0;
      if_filt_in = '0;
      for (int i = 0; i < 256; i++) hist[i] = 0;
      test_reset();
      test_zero();
      test_const_pos();
      test_neg_sat();
      test_am_tone();
      test_random();
      test_alternating();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
